// File: rtl/fetch_stage.sv
// Instruction fetch: drives an instruction-memory request interface and
// buffers returned words in a 2-entry {PC, instruction} FIFO for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] PCOut,
  output logic        InstrValid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] drop_addr_r, drop_addr_nxt_s;
  logic [31:0] pc0_r, ins0_r, pc1_r, ins1_r;
  logic [1:0]  count_r, count_nxt_s, count_after_pop_s;
  logic        pop_s, push_s;

  // Next-state, fetch PC and FIFO occupancy decisions
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    drop_addr_nxt_s = drop_addr_r;
    push_s          = 1'b0;
    pop_s           = (count_r != 2'd0) && !Stall && !Redirect;
    count_after_pop_s = count_r - {1'b0, pop_s};

    case (state_r)
      IDLE: begin
        if (Redirect) begin
          pc_nxt_s    = RedirectPC;
          state_nxt_s = IDLE;
        end else if (count_after_pop_s != 2'd2) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (Redirect) begin
          pc_nxt_s = RedirectPC;
          if (IMemAck) begin
            state_nxt_s = REQ;
          end else begin
            // keep the outstanding address stable while its response is drained
            drop_addr_nxt_s = pc_r;
            state_nxt_s     = DROP;
          end
        end else if (IMemAck) begin
          push_s      = 1'b1;
          pc_nxt_s    = pc_r + 32'd4;
          state_nxt_s = (count_after_pop_s == 2'd1) ? IDLE : REQ;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DROP: begin
        if (Redirect) begin
          pc_nxt_s = RedirectPC;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (IMemAck) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    if (Redirect) begin
      count_nxt_s = 2'd0;
    end else begin
      count_nxt_s = count_after_pop_s + {1'b0, push_s};
    end
  end

  // Control state and fetch PC registers
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      drop_addr_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      drop_addr_r <= drop_addr_nxt_s;
    end
  end

  // FIFO storage: slot 0 is the head presented to decode
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      count_r <= 2'd0;
      pc0_r   <= 32'h0000_0000;
      ins0_r  <= 32'h0000_0000;
      pc1_r   <= 32'h0000_0000;
      ins1_r  <= 32'h0000_0000;
    end else begin
      count_r <= count_nxt_s;
      if (push_s && (count_after_pop_s == 2'd0)) begin
        pc0_r  <= pc_r;
        ins0_r <= IMemData;
      end else if (pop_s) begin
        pc0_r  <= pc1_r;
        ins0_r <= ins1_r;
      end
      if (push_s && (count_after_pop_s == 2'd1)) begin
        pc1_r  <= pc_r;
        ins1_r <= IMemData;
      end
    end
  end

  assign IMemReq     = (state_r != IDLE);
  assign IMemAddr    = (state_r == DROP) ? drop_addr_r : pc_r;
  assign InstrValid  = (count_r != 2'd0);
  assign Instruction = InstrValid ? ins0_r : 32'h0000_0000;
  assign PCOut       = InstrValid ? pc0_r  : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall back-pressure,
// redirects (IDLE/REQ/DROP) and PC wrap with a non-zero RESET_PC.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        nreset0, stall0, redirect0, ack0, req0, valid0;
  logic [31:0] rpc0, addr0, data0, instr0, pcout0;
  logic        nreset1, ack1, req1, valid1;
  logic [31:0] addr1, data1, instr1, pcout1;
  logic [31:0] dmask;
  int          assert_cnt = 0;
  int          fail_cnt   = 0;

  always #5 clk = ~clk;

  // memory model: returned word is the address xor a per-test mask
  assign data0 = addr0 ^ dmask;
  assign data1 = addr1;

  fetch_stage dut0 (
    .Clock(clk), .nReset(nreset0), .Stall(stall0), .Redirect(redirect0),
    .RedirectPC(rpc0), .IMemReq(req0), .IMemAddr(addr0), .IMemAck(ack0),
    .IMemData(data0), .Instruction(instr0), .PCOut(pcout0), .InstrValid(valid0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .Clock(clk), .nReset(nreset1), .Stall(1'b0), .Redirect(1'b0),
    .RedirectPC(32'h0000_0000), .IMemReq(req1), .IMemAddr(addr1), .IMemAck(ack1),
    .IMemData(data1), .Instruction(instr1), .PCOut(pcout1), .InstrValid(valid1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset0 = 1'b0; stall0 = 1'b0; redirect0 = 1'b0; rpc0 = 32'h0; ack0 = 1'b0;
    nreset1 = 1'b0; ack1 = 1'b1; dmask = 32'h0;
    tick(); tick();
    check_eq("rst_req",   {31'd0, req0},   32'd0);
    check_eq("rst_valid", {31'd0, valid0}, 32'd0);
    check_eq("rst_instr", instr0, 32'h0);
    check_eq("rst_pcout", pcout0, 32'h0);

    // streaming with data = address
    nreset0 = 1'b1; ack0 = 1'b1;
    tick();
    check_eq("boot_req",  {31'd0, req0}, 32'd1);
    check_eq("boot_addr", addr0, 32'h0);
    check_eq("boot_valid", {31'd0, valid0}, 32'd0);
    tick();
    check_eq("s0_valid", {31'd0, valid0}, 32'd1);
    check_eq("s0_instr", instr0, 32'h0);
    check_eq("s0_addr",  addr0, 32'h4);
    tick();
    check_eq("s1_instr", instr0, 32'h4);
    check_eq("s1_pcout", pcout0, 32'h4);
    tick();
    check_eq("s2_instr", instr0, 32'h8);
    check_eq("s2_pcout", pcout0, 32'h8);
    check_eq("s2_valid", {31'd0, valid0}, 32'd1);

    // stall back-pressure: FIFO fills, request drops, then drains in order
    nreset0 = 1'b0; tick();
    nreset0 = 1'b1; stall0 = 1'b1; ack0 = 1'b1;
    tick(); tick(); tick();
    check_eq("full_req", {31'd0, req0}, 32'd0);
    tick(); tick();
    check_eq("stall_req",   {31'd0, req0}, 32'd0);
    check_eq("stall_valid", {31'd0, valid0}, 32'd1);
    check_eq("stall_instr", instr0, 32'h0);
    check_eq("stall_pcout", pcout0, 32'h0);
    stall0 = 1'b0;
    tick();
    check_eq("drain1_instr", instr0, 32'h4);
    check_eq("drain1_pcout", pcout0, 32'h4);
    check_eq("drain1_req",   {31'd0, req0}, 32'd1);
    check_eq("drain1_addr",  addr0, 32'h8);
    tick();
    check_eq("drain2_instr", instr0, 32'h8);
    check_eq("drain2_pcout", pcout0, 32'h8);

    // redirect while 0x8 is pending without ack -> DROP
    nreset0 = 1'b0; tick();
    nreset0 = 1'b1; ack0 = 1'b0; dmask = 32'h5A00_0000;
    tick();
    ack0 = 1'b1;
    tick();
    check_eq("m_instr0", instr0, 32'h5A00_0000);
    tick();
    ack0 = 1'b0;
    tick();
    check_eq("pend_addr",  addr0, 32'h8);
    check_eq("pend_valid", {31'd0, valid0}, 32'd0);
    redirect0 = 1'b1; rpc0 = 32'h100;
    tick();
    redirect0 = 1'b0;
    check_eq("drop_req",  {31'd0, req0}, 32'd1);
    check_eq("drop_addr", addr0, 32'h8);
    tick();
    check_eq("drop_hold", addr0, 32'h8);
    check_eq("drop_valid", {31'd0, valid0}, 32'd0);
    tick();
    ack0 = 1'b1;
    tick();
    check_eq("after_drop_addr",  addr0, 32'h100);
    check_eq("after_drop_valid", {31'd0, valid0}, 32'd0);
    tick();
    check_eq("rd_pcout", pcout0, 32'h100);
    check_eq("rd_instr", instr0, 32'h5A00_0100);

    // redirect with ack and stall in the same cycle flushes
    stall0 = 1'b1; redirect0 = 1'b1; rpc0 = 32'h200; ack0 = 1'b1;
    tick();
    check_eq("flush_valid", {31'd0, valid0}, 32'd0);
    check_eq("flush_instr", instr0, 32'h0);
    check_eq("flush_pcout", pcout0, 32'h0);
    check_eq("flush_addr",  addr0, 32'h200);
    redirect0 = 1'b0; stall0 = 1'b0;
    tick();
    check_eq("lat_instr", instr0, 32'h5A00_0200);
    check_eq("lat_pcout", pcout0, 32'h200);

    // last redirect wins in DROP, then reset while in DROP
    ack0 = 1'b0; redirect0 = 1'b1; rpc0 = 32'h300;
    tick();
    check_eq("drop2_addr",  addr0, 32'h204);
    check_eq("drop2_valid", {31'd0, valid0}, 32'd0);
    rpc0 = 32'h340;
    tick();
    redirect0 = 1'b0; ack0 = 1'b1;
    tick();
    check_eq("lastwin_addr", addr0, 32'h340);
    ack0 = 1'b0; redirect0 = 1'b1; rpc0 = 32'h400;
    tick();
    check_eq("drop3_addr", addr0, 32'h340);
    redirect0 = 1'b0; nreset0 = 1'b0; ack0 = 1'b1;
    tick();
    check_eq("rdrop_req",   {31'd0, req0}, 32'd0);
    check_eq("rdrop_valid", {31'd0, valid0}, 32'd0);
    check_eq("rdrop_instr", instr0, 32'h0);
    check_eq("rdrop_pcout", pcout0, 32'h0);
    nreset0 = 1'b1;
    tick();
    check_eq("restart_req",  {31'd0, req0}, 32'd1);
    check_eq("restart_addr", addr0, 32'h0);
    tick();
    check_eq("restart_pcout", pcout0, 32'h0);
    check_eq("restart_instr", instr0, 32'h5A00_0000);

    // PC wrap with RESET_PC = FFFF_FFF8
    check_eq("w_rst_req", {31'd0, req1}, 32'd0);
    nreset1 = 1'b1;
    tick();
    check_eq("w_addr0", addr1, 32'hFFFF_FFF8);
    tick();
    check_eq("w_addr1",  addr1, 32'hFFFF_FFFC);
    check_eq("w_pcout0", pcout1, 32'hFFFF_FFF8);
    tick();
    check_eq("w_addr2",  addr1, 32'h0000_0000);
    check_eq("w_pcout1", pcout1, 32'hFFFF_FFFC);
    tick();
    check_eq("w_pcout2", pcout1, 32'h0000_0000);
    check_eq("w_instr2", instr1, 32'h0000_0000);
    check_eq("w_valid",  {31'd0, valid1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
